stopwatch_ctrl: RTL and testbench

Command sequencer and arbiter in front of the stopwatch datapath (start/stop/reset inputs; minute[7:0]/seconds[5:0] outputs).
- Merges two command sources into single-cycle control pulses: local (already debounced) buttons and a host valid/ready command port.
- Tracks run state.
- Captures lap times into a small FIFO that a display or host drains.

---
 rtl/stopwatch_pkg.sv | 31 +++
 rtl/stopwatch_lap_fifo.sv | 74 +++++++
 rtl/stopwatch_ctrl.sv | 175 +++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared encodings and default widths for the stopwatch control slice.
package stopwatch_pkg;

  localparam int unsigned MIN_W_DEF = 8;
  localparam int unsigned SEC_W_DEF = 6;
  localparam int unsigned LAP_W_DEF = MIN_W_DEF + SEC_W_DEF;

  // Bit positions of the buttons in the packed edge/pending vectors
  localparam int unsigned B_START = 0;
  localparam int unsigned B_STOP  = 1;
  localparam int unsigned B_LAP   = 2;
  localparam int unsigned B_CLEAR = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2
  } sw_state_e;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_STOP  = 2'd1,
    OP_LAP   = 2'd2,
    OP_CLEAR = 2'd3
  } sw_op_e;

  function automatic int unsigned lap_width(input int unsigned min_w, input int unsigned sec_w);
    return min_w + sec_w;
  endfunction

endpackage

// File: rtl/stopwatch_lap_fifo.sv
// Lap-time FIFO: synchronous push/pop, flush, occupancy count and sticky overflow.
module stopwatch_lap_fifo
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = LAP_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic                     valid,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt_q;
  logic             ovf_q;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == (PTR_W+1)'(DEPTH));
    do_pop  = pop & ~empty;
    // A simultaneous pop frees the slot a full-FIFO push needs
    do_push = push & (~full | do_pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (push && !do_push) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  always_comb begin
    valid    = ~empty;
    dout     = empty ? '0 : mem[rd_ptr];
    count    = cnt_q;
    overflow = ovf_q;
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch command sequencer: button edge detect, button/host arbiter, run-state FSM, lap FIFO.
// Define STOPWATCH_AUTO_LAP_EN to also capture a lap on every STOP taken while running.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned LAP_DEPTH = 4,
  parameter int unsigned MIN_W     = MIN_W_DEF,
  parameter int unsigned SEC_W     = SEC_W_DEF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          btn_start,
  input  logic                          btn_stop,
  input  logic                          btn_lap,
  input  logic                          btn_clear,
  input  logic                          cmd_valid,
  input  logic [1:0]                    cmd_op,
  output logic                          cmd_ready,
  output logic                          sw_start,
  output logic                          sw_stop,
  output logic                          sw_reset,
  input  logic [MIN_W-1:0]              minute,
  input  logic [SEC_W-1:0]              seconds,
  output logic [1:0]                    state,
  output logic                          lap_valid,
  input  logic                          lap_ready,
  output logic [MIN_W+SEC_W-1:0]        lap_data,
  output logic [$clog2(LAP_DEPTH):0]    lap_count,
  output logic                          lap_overflow
);

  localparam int unsigned LAP_W = lap_width(MIN_W, SEC_W);

  logic [3:0] btn_lvl;
  logic [3:0] btn_q;
  logic [3:0] rise;
  logic [3:0] pend_q;
  logic [3:0] pend_eff;
  logic [3:0] gnt_btn;
  logic       host_acc;
  logic       gnt_vld;
  sw_op_e     gnt_op;

  sw_state_e  state_q;
  sw_state_e  state_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       reset_q, reset_d;
  logic       lap_push;
  logic       fifo_flush;

  // A fresh edge counts as pending in its own cycle so it can be granted immediately
  always_comb begin
    btn_lvl  = {btn_clear, btn_lap, btn_stop, btn_start};
    rise     = btn_lvl & ~btn_q;
    pend_eff = pend_q | rise;
  end

  assign cmd_ready = reset_n & ~pend_eff[B_CLEAR];
  assign host_acc  = cmd_valid & cmd_ready;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_op  = OP_START;
    gnt_btn = '0;
    if (pend_eff[B_CLEAR]) begin
      gnt_vld          = 1'b1;
      gnt_op           = OP_CLEAR;
      gnt_btn[B_CLEAR] = 1'b1;
    end else if (host_acc) begin
      gnt_vld = 1'b1;
      gnt_op  = sw_op_e'(cmd_op);
    end else if (pend_eff[B_STOP]) begin
      gnt_vld         = 1'b1;
      gnt_op          = OP_STOP;
      gnt_btn[B_STOP] = 1'b1;
    end else if (pend_eff[B_START]) begin
      gnt_vld          = 1'b1;
      gnt_op           = OP_START;
      gnt_btn[B_START] = 1'b1;
    end else if (pend_eff[B_LAP]) begin
      gnt_vld        = 1'b1;
      gnt_op         = OP_LAP;
      gnt_btn[B_LAP] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_q  <= '0;
      pend_q <= '0;
    end else begin
      btn_q  <= btn_lvl;
      pend_q <= pend_eff & ~gnt_btn;
    end
  end

  // State register with the registered control pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      reset_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      reset_q <= reset_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    reset_d    = 1'b0;
    lap_push   = 1'b0;
    fifo_flush = 1'b0;
    if (gnt_vld) begin
      case (gnt_op)
        OP_CLEAR: begin
          state_d    = ST_IDLE;
          reset_d    = 1'b1;
          fifo_flush = 1'b1;
        end
        OP_START: begin
          if (state_q == ST_IDLE || state_q == ST_PAUSED) begin
            state_d = ST_RUNNING;
            start_d = 1'b1;
          end
        end
        OP_STOP: begin
          if (state_q == ST_RUNNING) begin
            state_d = ST_PAUSED;
            stop_d  = 1'b1;
`ifdef STOPWATCH_AUTO_LAP_EN
            lap_push = 1'b1;
`else
            lap_push = 1'b0;
`endif
          end
        end
        OP_LAP: begin
          if (state_q == ST_RUNNING || state_q == ST_PAUSED) lap_push = 1'b1;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    sw_start = start_q;
    sw_stop  = stop_q;
    sw_reset = reset_q;
    state    = state_q;
  end

  stopwatch_lap_fifo #(
    .DEPTH (LAP_DEPTH),
    .WIDTH (LAP_W)
  ) u_lap_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (lap_push),
    .pop      (lap_ready),
    .flush    (fifo_flush),
    .din      ({minute, seconds}),
    .valid    (lap_valid),
    .dout     (lap_data),
    .count    (lap_count),
    .overflow (lap_overflow)
  );

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl (LAP_DEPTH=4, MIN_W=8, SEC_W=6).
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        btn_start, btn_stop, btn_lap, btn_clear;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic        cmd_ready;
  logic        sw_start, sw_stop, sw_reset;
  logic [7:0]  minute;
  logic [5:0]  seconds;
  logic [1:0]  state;
  logic        lap_valid;
  logic        lap_ready;
  logic [13:0] lap_data;
  logic [2:0]  lap_count;
  logic        lap_overflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .LAP_DEPTH (4),
    .MIN_W     (8),
    .SEC_W     (6)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn_start    (btn_start),
    .btn_stop     (btn_stop),
    .btn_lap      (btn_lap),
    .btn_clear    (btn_clear),
    .cmd_valid    (cmd_valid),
    .cmd_op       (cmd_op),
    .cmd_ready    (cmd_ready),
    .sw_start     (sw_start),
    .sw_stop      (sw_stop),
    .sw_reset     (sw_reset),
    .minute       (minute),
    .seconds      (seconds),
    .state        (state),
    .lap_valid    (lap_valid),
    .lap_ready    (lap_ready),
    .lap_data     (lap_data),
    .lap_count    (lap_count),
    .lap_overflow (lap_overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    tick();
    cmd_valid = 1'b0;
  endtask

  function automatic logic [31:0] lapv(input int m, input int s);
    return 32'(m * 64 + s);
  endfunction

  int pulses;
`ifdef STOPWATCH_AUTO_LAP_EN
  localparam int AUTO = 1;
`else
  localparam int AUTO = 0;
`endif

  initial begin
    reset_n = 1'b0;
    btn_start = 0; btn_stop = 0; btn_lap = 0; btn_clear = 0;
    cmd_valid = 0; cmd_op = 0; lap_ready = 0;
    minute = 0; seconds = 0;
    repeat (3) tick();
    check("rst_state", state, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_sw_start", sw_start, 0);
    check("rst_sw_reset", sw_reset, 0);
    check("rst_lap_valid", lap_valid, 0);
    check("rst_lap_count", lap_count, 0);
    check("rst_overflow", lap_overflow, 0);
    check("rst_lap_data", lap_data, 0);
    reset_n = 1'b1;
    #1;
    check("cmd_ready_after_rst", cmd_ready, 1);
    tick();
    tick();

    // Button START edge, then hold
    btn_start = 1'b1;
    tick();
    check("btn_start_pulse", sw_start, 1);
    check("btn_start_state", state, 1);
    pulses = 0;
    repeat (10) begin
      tick();
      if (sw_start) pulses++;
    end
    check("held_start_no_repulse", pulses, 0);
    btn_start = 1'b0;

    // Single host LAP and pop
    minute = 8'd2; seconds = 6'd37;
    host(2'd2);
    check("lap1_valid", lap_valid, 1);
    check("lap1_data", lap_data, lapv(2, 37));
    check("lap1_count", lap_count, 1);
    lap_ready = 1'b1;
    tick();
    lap_ready = 1'b0;
    check("lap1_popped", lap_valid, 0);

    // Five laps into four slots
    for (int i = 1; i <= 5; i++) begin
      seconds = 6'(i);
      host(2'd2);
    end
    check("full_count", lap_count, 4);
    check("full_overflow", lap_overflow, 1);
    check("full_head", lap_data, lapv(2, 1));
    seconds = 6'd6;
    lap_ready = 1'b1;
    host(2'd2);
    lap_ready = 1'b0;
    check("pushpop_count", lap_count, 4);
    check("pushpop_head", lap_data, lapv(2, 2));

    host(2'd3);
    check("clear_sw_reset", sw_reset, 1);
    check("clear_state", state, 0);
    check("clear_count", lap_count, 0);
    check("clear_overflow", lap_overflow, 0);
    check("clear_valid", lap_valid, 0);
    tick();
    check("clear_single_pulse", sw_reset, 0);

    // Full FIFO with simultaneous pop must not flag overflow
    host(2'd0);
    check("restart_pulse", sw_start, 1);
    check("restart_state", state, 1);
    for (int i = 10; i <= 13; i++) begin
      seconds = 6'(i);
      host(2'd2);
    end
    seconds = 6'd14;
    lap_ready = 1'b1;
    host(2'd2);
    lap_ready = 1'b0;
    check("pushpop_full_count", lap_count, 4);
    check("pushpop_full_no_ovf", lap_overflow, 0);
    check("pushpop_full_head", lap_data, lapv(2, 11));
    lap_ready = 1'b1;
    repeat (4) tick();
    lap_ready = 1'b0;
    check("drained", lap_count, 0);

    // Host STOP beats button LAP edge in the same cycle
    minute = 8'd3; seconds = 6'd20;
    cmd_valid = 1'b1; cmd_op = 2'd1; btn_lap = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("host_wins_stop", sw_stop, 1);
    check("host_wins_state", state, 2);
    check("host_wins_count", lap_count, 3'(AUTO));
    tick();
    check("btn_lap_late_stop_low", sw_stop, 0);
    check("btn_lap_late_count", lap_count, 3'(AUTO + 1));
    check("btn_lap_late_data", lap_data, lapv(3, 20));
    btn_lap = 1'b0;
    lap_ready = 1'b1;
    repeat (2) tick();
    lap_ready = 1'b0;
    check("drained2", lap_valid, 0);

    host(2'd1);
    check("paused_stop_ignored", sw_stop, 0);
    check("paused_state", state, 2);
    host(2'd0);
    check("resume_pulse", sw_start, 1);
    check("resume_state", state, 1);

    // Button CLEAR blocks host START for one cycle
    btn_clear = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd0;
    #1;
    check("clear_blocks_ready", cmd_ready, 0);
    tick();
    check("btnclr_sw_reset", sw_reset, 1);
    check("btnclr_state", state, 0);
    check("btnclr_ready_back", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    check("after_clr_start", sw_start, 1);
    check("after_clr_reset_low", sw_reset, 0);
    check("after_clr_state", state, 1);
    btn_clear = 1'b0;

    // Asynchronous reset with laps stored
    minute = 8'd4;
    for (int i = 30; i <= 32; i++) begin
      seconds = 6'(i);
      host(2'd2);
    end
    check("three_laps", lap_count, 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_state", state, 0);
    check("async_count", lap_count, 0);
    check("async_valid", lap_valid, 0);
    check("async_ready", cmd_ready, 0);
    check("async_data", lap_data, 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_valid", lap_valid, 0);
    check("post_rst_state", state, 0);

    // IDLE ignores LAP and STOP
    host(2'd2);
    check("idle_lap_no_push", lap_count, 0);
    host(2'd1);
    check("idle_stop_no_pulse", sw_stop, 0);
    check("idle_stop_state", state, 0);

    // STOP while running: FIFO touched only with auto-lap
    host(2'd0);
    minute = 8'd1; seconds = 6'd5;
    host(2'd1);
    check("stop105_pulse", sw_stop, 1);
    check("stop105_count", lap_count, 3'(AUTO));
    if (AUTO != 0) check("stop105_data", lap_data, lapv(1, 5));
    lap_ready = 1'b1;
    tick();
    lap_ready = 1'b0;

    // Button STOP outranks button LAP; LAP follows in PAUSED
    host(2'd0);
    minute = 8'd5; seconds = 6'd9;
    btn_stop = 1'b1; btn_lap = 1'b1;
    tick();
    check("btn_prio_stop", sw_stop, 1);
    check("btn_prio_state", state, 2);
    tick();
    check("btn_prio_lap_count", lap_count, 3'(AUTO + 1));
    check("btn_prio_lap_data", lap_data, lapv(5, 9));
    btn_stop = 1'b0; btn_lap = 1'b0;

    // Flush and pop in the same cycle
    lap_ready = 1'b1;
    host(2'd3);
    lap_ready = 1'b0;
    check("flush_pop_valid", lap_valid, 0);
    check("flush_pop_count", lap_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
